cnn_sample_loader: RTL and testbench
====================================

Name: cnn_sample_loader

Overview:
- Upstream feeder for the modular CNN top: receives one training sample as a valid/ready word stream (16 pixels row-major, then the label) in Q8.8.
- Assembles each sample into one of two ping-pong banks and presents the bank as the CNN's image and label inputs.
- Pulses the CNN start and holds the bank stable until the CNN reports done, so the next sample loads while the current one trains.

Parameters:
IMG_SIZE, 4, image height and width in pixels; words per sample = IMG_SIZE*IMG_SIZE + 1
DATA_W, 16, word width (Q8.8 signed)
CNT_W, 16, width of sample_count

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word: pixels row-major, then label
s_last  in  1  marks final word (label) of a sample
s_ready  out  1  loader can accept s_data this cycle
image  out  DATA_W x [IMG_SIZE][IMG_SIZE]  signed pixels of dispatched bank
label  out  DATA_W  signed label of dispatched bank
cnn_start  out  1  one-cycle start pulse to CNN
cnn_done  in  1  CNN completion; rising edge is used
busy  out  1  a sample is dispatched and awaiting cnn_done
sample_count  out  CNT_W  samples completed by CNN, wraps at 2^CNT_W
err_framing  out  1  sticky framing-error flag

Behaviour:
- Reset (rst=0, asynchronous): both banks zeroed; wr_bank=rd_bank=0; bank_full[1:0]=0; word index 0; fill FSM=FILL; dispatch FSM=D_IDLE.
- Output reset values: cnn_start=0, busy=0, sample_count=0, err_framing=0, s_ready=0 during reset. image and label read 0.
- Reset mid-sample discards all buffered data. No cnn_start is issued for it.
- A word is transferred on a cycle with s_valid && s_ready.
- Fill FSM states: FILL and DROP.
- FILL:
  - s_ready = !bank_full[wr_bank].
  - Word index i < N=IMG_SIZE^2 writes bank[wr_bank] pixel [i/IMG_SIZE][i%IMG_SIZE].
  - Index i == N writes the label.
- Framing:
  - Correct sample: s_last=0 for i<N and s_last=1 at i==N. Then set bank_full[wr_bank], toggle wr_bank, set index to 0.
  - s_last=1 at i<N: set err_framing, discard the partial sample (bank_full unchanged), set index to 0, stay in FILL.
  - s_last=0 at i==N: set err_framing, discard, go to DROP.
- DROP: s_ready=1. Swallow words until a transfer with s_last=1, then go to FILL with index 0.
- err_framing clears only on reset.
- Dispatch FSM states: D_IDLE, D_START, D_WAIT.
  - D_IDLE: if bank_full[rd_bank], go to D_START.
  - D_START: cnn_start=1 for exactly this cycle; go to D_WAIT.
  - D_WAIT: busy=1. On a cnn_done rising edge (cnn_done=1 and its registered previous value 0): clear bank_full[rd_bank], toggle rd_bank, increment sample_count, go to D_IDLE.
  - cnn_done edges outside D_WAIT are ignored.
- image and label continuously mux bank[rd_bank]. The muxed bank is never written while bank_full[rd_bank]=1, so the outputs are stable from D_START through D_WAIT.
- Latency: label accepted in cycle T → bank_full set in T+1 → cnn_start=1 in T+2, if the dispatcher was idle on that bank.
- Back-to-back dispatch: after release in cycle R, a full next bank gives cnn_start in R+2.
- Simultaneous events:
  - Fill completion and dispatch release in the same cycle act on different banks; both take effect.
  - If both banks are full, s_ready=0 until release. The bank freed by release is fillable from the next cycle.
- Arithmetic: data is stored verbatim with no saturation or conversion. sample_count wraps modulo 2^CNT_W.

Test Plan:
- Single sample: stream words 0x0100..0x1000 (16 pixels) then label 0x0080 with s_last, no stalls. Expect image[0][0]=0x0100, image[3][3]=0x1000, label=0x0080, and one cnn_start pulse 2 cycles after the label. Pulse cnn_done 40 cycles later → sample_count=1, busy=0.
- Ping-pong: stream 3 samples back-to-back with cnn_done held off. Expect s_ready=0 after sample 2 and image still showing sample 1. On cnn_done, expect sample 2 dispatched with cnn_start 2 cycles later and s_ready=1; sample 3 then fills.
- Early s_last: assert s_last on word 5, then send a correct sample. Expect err_framing=1, no cnn_start for the bad sample, and the correct sample dispatched normally.
- Missing s_last: send 17 words without s_last, 3 junk words, one word with s_last, then a correct sample. Expect DROP to swallow all junk and exactly one dispatch (the correct sample).
- Reset mid-operation: deassert rst in the middle of sample 2 while sample 1 is in D_WAIT. Expect all outputs 0 immediately, and no cnn_start until a full new sample arrives.
- Stray cnn_done: pulse cnn_done in D_IDLE. Expect sample_count unchanged. Also check sample_count wraps 0xFFFF→0 (force preload or CNT_W=2 variant).

Source files
------------

// File: rtl/cnn_sample_loader.sv
// Ping-pong sample loader for the CNN: assembles streamed Q8.8 samples into two banks
// and hands each full bank to the CNN with a start pulse, releasing it on done.
//
// fill FSM   | meaning
// FILL       | writing words into bank[wr_bank]; stalls while that bank is full
// DROP       | resyncing after a missing s_last; swallow words up to the next s_last
//
// dispatch   | meaning
// D_IDLE     | waiting for bank[rd_bank] to become full
// D_START    | one-cycle cnn_start pulse
// D_WAIT     | CNN running on bank[rd_bank]; waiting for cnn_done rising edge
module cnn_sample_loader #(
    parameter int IMG_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          s_valid,
    input  logic [DATA_W-1:0]                             s_data,
    input  logic                                          s_last,
    output logic                                          s_ready,
    output logic [IMG_SIZE-1:0][IMG_SIZE-1:0][DATA_W-1:0] image,
    output logic signed [DATA_W-1:0]                      label,
    output logic                                          cnn_start,
    input  logic                                          cnn_done,
    output logic                                          busy,
    output logic [CNT_W-1:0]                              sample_count,
    output logic                                          err_framing
);
    localparam int RC_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(IMG_SIZE - 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] DROP = 1'b1;

    localparam logic [1:0] D_IDLE  = 2'd0;
    localparam logic [1:0] D_START = 2'd1;
    localparam logic [1:0] D_WAIT  = 2'd2;

    logic [1:0][IMG_SIZE-1:0][IMG_SIZE-1:0][DATA_W-1:0] bank_img;
    logic [1:0][DATA_W-1:0]                             bank_lbl;
    logic [1:0]      bank_full;
    logic            wr_bank;
    logic            rd_bank;
    logic [0:0]      fill_state;
    logic [1:0]      disp_state;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    logic            lbl_phase;
    logic            done_q;

    logic       xfer;
    logic       fill_done;
    logic       done_rise;
    logic       release_bank;
    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    // rst is folded in so the stream sees no ready while the loader is held in reset
    assign s_ready      = rst && ((fill_state == DROP) || !bank_full[wr_bank]);
    assign xfer         = s_valid && s_ready;
    assign fill_done    = xfer && (fill_state == FILL) && lbl_phase && s_last;
    assign done_rise    = cnn_done && !done_q;
    assign release_bank = (disp_state == D_WAIT) && done_rise;
    assign set_mask     = {fill_done && wr_bank, fill_done && !wr_bank};
    assign clr_mask     = {release_bank && rd_bank, release_bank && !rd_bank};

    assign cnn_start = (disp_state == D_START);
    assign busy      = (disp_state == D_WAIT);
    assign image     = bank_img[rd_bank];
    assign label     = bank_lbl[rd_bank];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_img    <= '0;
            bank_lbl    <= '0;
            wr_bank     <= 1'b0;
            fill_state  <= FILL;
            row         <= '0;
            col         <= '0;
            lbl_phase   <= 1'b0;
            err_framing <= 1'b0;
        end else if (xfer) begin
            if (fill_state == DROP) begin
                if (s_last) begin
                    fill_state <= FILL;
                end
            end else if (!lbl_phase) begin
                if (s_last) begin
                    err_framing <= 1'b1;
                    row         <= '0;
                    col         <= '0;
                end else begin
                    bank_img[wr_bank][row][col] <= s_data;
                    if (col == RC_LAST) begin
                        col <= '0;
                        if (row == RC_LAST) begin
                            row       <= '0;
                            lbl_phase <= 1'b1;
                        end else begin
                            row <= row + RC_W'(1);
                        end
                    end else begin
                        col <= col + RC_W'(1);
                    end
                end
            end else begin
                lbl_phase <= 1'b0;
                if (s_last) begin
                    bank_lbl[wr_bank] <= s_data;
                    wr_bank           <= !wr_bank;
                end else begin
                    err_framing <= 1'b1;
                    fill_state  <= DROP;
                end
            end
        end
    end

    // Set and clear always target different banks, so both may land in one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= (bank_full | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_state   <= D_IDLE;
            rd_bank      <= 1'b0;
            sample_count <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= cnn_done;
            case (disp_state)
                D_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        disp_state <= D_START;
                    end
                end
                D_START: begin
                    disp_state <= D_WAIT;
                end
                D_WAIT: begin
                    if (done_rise) begin
                        rd_bank      <= !rd_bank;
                        sample_count <= sample_count + CNT_W'(1);
                        disp_state   <= D_IDLE;
                    end
                end
                default: begin
                    disp_state <= D_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_sample_loader.sv
// Directed bench for cnn_sample_loader: a sample-queue model checked every cycle plus
// hand-computed expectations for latency, framing errors, reset and count wrap.
module tb_cnn_sample_loader;
    typedef logic [16:0][15:0] frame_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic s_last = 1'b0;
    logic cnn_done = 1'b0;
    logic s_ready;
    logic [3:0][3:0][15:0] image;
    logic signed [15:0] label;
    logic cnn_start;
    logic busy;
    logic [15:0] sample_count;
    logic err_framing;

    logic s_ready2;
    logic [3:0][3:0][15:0] image2;
    logic signed [15:0] label2;
    logic cnn_start2;
    logic busy2;
    logic [1:0] sample_count2;
    logic err_framing2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_q[$];

    cnn_sample_loader dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .image(image), .label(label), .cnn_start(cnn_start),
        .cnn_done(cnn_done), .busy(busy), .sample_count(sample_count),
        .err_framing(err_framing)
    );

    cnn_sample_loader #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready2), .image(image2), .label(label2), .cnn_start(cnn_start2),
        .cnn_done(cnn_done), .busy(busy2), .sample_count(sample_count2),
        .err_framing(err_framing2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: completed samples wait in a FIFO of at most two; the head is the one
    // dispatched, starting one cycle after it is both full and the CNN is free.
    frame_t m_q[$];
    int     m_full_q[$];
    frame_t m_cur = '0;
    int     m_k = 0;
    bit     m_drop = 0;
    bit     m_err = 0;
    logic [15:0] m_cnt = '0;
    bit     m_done_prev = 0;
    bit     m_svc = 0;
    int     m_start = 0;
    int     m_rel = -100;
    int     m_e = 0;
    bit     m_x;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete(); m_full_q.delete();
            m_cur = '0; m_k = 0; m_drop = 0; m_err = 0; m_cnt = '0;
            m_done_prev = 0; m_svc = 0; m_start = 0; m_rel = -100; m_e = 0;
        end else begin
            m_e = m_e + 1;
            m_x = s_valid && (m_drop || m_q.size() < 2);
            if (m_svc && (m_e - 1) > m_start && cnn_done && !m_done_prev) begin
                void'(m_q.pop_front());
                void'(m_full_q.pop_front());
                m_cnt = m_cnt + 16'd1;
                m_svc = 0;
                m_rel = m_e;
            end
            if (m_x) begin
                if (m_drop) begin
                    if (s_last) m_drop = 0;
                end else if (m_k < 16) begin
                    if (s_last) begin m_err = 1; m_k = 0; end
                    else begin m_cur[m_k] = s_data; m_k = m_k + 1; end
                end else begin
                    m_k = 0;
                    if (s_last) begin
                        m_cur[16] = s_data;
                        m_q.push_back(m_cur);
                        m_full_q.push_back(m_e);
                    end else begin
                        m_err = 1; m_drop = 1;
                    end
                end
            end
            if (!m_svc && m_q.size() > 0) begin
                m_start = ((m_full_q[0] > m_rel) ? m_full_q[0] : m_rel) + 1;
                m_svc = 1;
            end
            m_done_prev = cnn_done;
        end
    end

    frame_t hf;
    logic [3:0][3:0][15:0] ei;
    always @(negedge clk) begin
        if (cnn_start) start_q.push_back(cyc);
        chk("s_ready", s_ready, rst && (m_drop || m_q.size() < 2));
        chk("cnn_start", cnn_start, m_svc && (m_e == m_start));
        chk("busy", busy, m_svc && (m_e > m_start));
        chk("sample_count", sample_count, m_cnt);
        chk("sample_count_w2", sample_count2, m_cnt[1:0]);
        chk("err_framing", err_framing, m_err);
        if (m_svc) begin
            hf = m_q[0];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    ei[r][c] = hf[r*4+c];
            chk("image", image, ei);
            chk("label", $unsigned(label), hf[16]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, output int acc_edge);
        bit acc = 0;
        int tries = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                tries++;
                if (tries > 400) begin
                    tests++; fails++;
                    $display("FAIL send_timeout: s_ready stayed 0 for word %0h", d);
                    break;
                end
            end
        end
        acc_edge = cyc;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_sample(input frame_t f, output int acc_edge);
        for (int i = 0; i < 17; i++) send_word(f[i], i == 16, acc_edge);
    endtask

    function automatic frame_t mk(input logic [15:0] base, input logic [15:0] step,
                                  input logic [15:0] lbl);
        frame_t f;
        for (int i = 0; i < 16; i++) f[i] = base + step * 16'(i);
        f[16] = lbl;
        return f;
    endfunction

    task automatic pulse_done(output int e);
        e = cyc;
        cnn_done = 1'b1;
        tick(1);
        cnn_done = 1'b0;
    endtask

    frame_t f0, fa, fb, fc, f1, f2, f3;
    int acc, a1, a2, a3, n0, de, g, dummy;
    bit s2_done = 0;

    initial begin
        f0 = mk(16'h0100, 16'h0100, 16'h0080);
        fa = mk(16'h0A00, 16'h0003, 16'h0A0A);
        fb = mk(16'h0B00, 16'h0005, 16'hFB00);
        fc = mk(16'h0C10, 16'h0011, 16'h0C0C);
        f1 = mk(16'h1100, 16'h0001, 16'h1111);
        f2 = mk(16'h2200, 16'h0002, 16'h2222);
        f3 = mk(16'h3300, 16'h0004, 16'h3333);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", cnn_start, 1'b0);
        chk("rst_count", sample_count, 16'd0);
        chk("rst_err", err_framing, 1'b0);
        chk("rst_image", image, 256'd0);
        chk("rst_label", $unsigned(label), 16'd0);
        rst = 1'b1;
        tick(2);

        // single sample
        send_sample(f0, acc);
        tick(3);
        chk("t1_start_count", start_q.size(), 1);
        chk("t1_start_latency", start_q[0], acc + 1);
        chk("t1_img00", image[0][0], 16'h0100);
        chk("t1_img33", image[3][3], 16'h1000);
        chk("t1_label", $unsigned(label), 16'h0080);
        chk("t1_busy", busy, 1'b1);
        tick(40);
        pulse_done(de);
        tick(3);
        chk("t1_count", sample_count, 16'd1);
        chk("t1_busy_clr", busy, 1'b0);

        // stray cnn_done while idle
        pulse_done(de);
        tick(3);
        chk("stray_count", sample_count, 16'd1);
        chk("stray_no_start", start_q.size(), 1);

        // reset while one sample runs and the next is half loaded
        send_sample(fa, acc);
        tick(4);
        chk("rm_busy_before", busy, 1'b1);
        for (int i = 0; i < 8; i++) send_word(16'h0E00 + 16'(i), 1'b0, dummy);
        rst = 1'b0;
        #1;
        chk("rm_s_ready", s_ready, 1'b0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_start", cnn_start, 1'b0);
        chk("rm_count", sample_count, 16'd0);
        chk("rm_image", image, 256'd0);
        chk("rm_label", $unsigned(label), 16'd0);
        tick(2);
        rst = 1'b1;
        n0 = start_q.size();
        tick(20);
        chk("rm_no_start", start_q.size(), n0);

        // early s_last on word 5
        for (int i = 0; i < 5; i++) send_word(16'h2000 + 16'(i), i == 4, dummy);
        tick(2);
        chk("early_err", err_framing, 1'b1);
        tick(20);
        chk("early_no_start", start_q.size(), n0);
        send_sample(fb, acc);
        tick(3);
        chk("early_good_start", start_q.size(), n0 + 1);
        chk("early_good_latency", start_q[$], acc + 1);
        chk("early_good_label", $unsigned(label), 16'hFB00);
        chk("early_good_img12", image[1][2], 16'h0B1E);
        pulse_done(de);
        tick(3);
        chk("early_count", sample_count, 16'd1);

        // missing s_last, junk, resync, then a good sample
        n0 = start_q.size();
        for (int i = 0; i < 17; i++) send_word(16'h3000 + 16'(i), 1'b0, dummy);
        for (int i = 0; i < 3; i++) send_word(16'h7E00 + 16'(i), 1'b0, dummy);
        send_word(16'h3FFF, 1'b1, dummy);
        tick(20);
        chk("miss_no_start", start_q.size(), n0);
        chk("miss_ready", s_ready, 1'b1);
        send_sample(fc, acc);
        tick(3);
        chk("miss_one_start", start_q.size(), n0 + 1);
        chk("miss_latency", start_q[$], acc + 1);
        chk("miss_label", $unsigned(label), 16'h0C0C);
        pulse_done(de);
        tick(3);
        chk("miss_count", sample_count, 16'd2);

        // ping-pong with cnn_done held off
        n0 = start_q.size();
        fork
            begin
                send_sample(f1, a1);
                send_sample(f2, a2);
                s2_done = 1;
                send_sample(f3, a3);
            end
            begin
                g = 0;
                while (!s2_done && g < 500) begin tick(1); g++; end
                chk("pp_s2_loaded", s2_done, 1'b1);
                tick(3);
                chk("pp_ready_full", s_ready, 1'b0);
                chk("pp_img_s1", image[0][0], 16'h1100);
                chk("pp_label_s1", $unsigned(label), 16'h1111);
                chk("pp_one_start", start_q.size(), n0 + 1);
                tick(20);
                pulse_done(de);
                chk("pp_ready_after_rel", s_ready, 1'b1);
                tick(3);
                chk("pp_s2_start", start_q.size(), n0 + 2);
                chk("pp_s2_latency", start_q[$], de + 2);
                chk("pp_img_s2", image[3][3], 16'h221E);
                chk("pp_count3", sample_count, 16'd3);
            end
        join
        tick(5);
        pulse_done(de);
        tick(3);
        chk("wrap_count4", sample_count, 16'd4);
        chk("wrap_w2_zero", sample_count2, 2'd0);
        chk("pp_s3_start", start_q.size(), n0 + 3);
        chk("pp_label_s3", $unsigned(label), 16'h3333);
        tick(5);
        pulse_done(de);
        tick(3);
        chk("final_count5", sample_count, 16'd5);
        chk("final_w2_one", sample_count2, 2'd1);
        chk("final_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
